// File: rtl/sdpram_fifo_pkg.sv
// Shared helpers for the SDP-RAM backed stream FIFO: width derivations and
// the non-power-of-two pointer wrap.
package sdpram_fifo_pkg;

    function automatic int cnt_width(input int depth, input int rd_latency);
        return $clog2(depth + rd_latency + 3);
    endfunction

    function automatic int obuf_depth(input int rd_latency);
        return rd_latency + 2;
    endfunction

    function automatic logic [31:0] next_ptr(input logic [31:0] ptr, input logic [31:0] depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/sdpram_fifo_obuf.sv
// Small register FIFO that absorbs RAM read data and presents a registered
// valid/ready head.
module sdpram_fifo_obuf
    import sdpram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 72,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]      obuf_cnt
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [IDX_W-1:0]      wr_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic                  pop;

    assign out_valid = (obuf_cnt != '0);
    assign out_data  = mem[rd_idx];
    assign pop       = out_valid & out_ready;

    // Storage carries no reset; only the indices and occupancy define contents.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx   <= '0;
            rd_idx   <= '0;
            obuf_cnt <= '0;
        end else begin
            if (wr_en) wr_idx <= IDX_W'(next_ptr(32'(wr_idx), 32'(DEPTH)));
            if (pop)   rd_idx <= IDX_W'(next_ptr(32'(rd_idx), 32'(DEPTH)));
            case ({wr_en, pop})
                2'b10:   obuf_cnt <= obuf_cnt + CNT_W'(1);
                2'b01:   obuf_cnt <= obuf_cnt - CNT_W'(1);
                default: obuf_cnt <= obuf_cnt;
            endcase
        end
    end

endmodule

// File: rtl/sdpram_stream_fifo_ctrl.sv
// Stream FIFO controller driving an external simple-dual-port RAM; hides the
// RAM read latency behind an in-flight tracker and a small output buffer.
module sdpram_stream_fifo_ctrl
    import sdpram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 72,
    parameter int DEPTH      = 128,
    parameter int RD_LATENCY = 2,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int CNT_WIDTH  = cnt_width(DEPTH, RD_LATENCY)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  ram_wea,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [DATA_WIDTH-1:0] ram_dina,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    input  logic [DATA_WIDTH-1:0] ram_doutb,
    input  logic                  ram_init_done,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  full,
    output logic                  empty
);

    localparam int OBUF_DEPTH = obuf_depth(RD_LATENCY);
    localparam int OBUF_CW    = $clog2(OBUF_DEPTH + 1);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   ram_cnt;
    logic [RD_LATENCY-1:0] rd_vld;
    logic [CNT_WIDTH-1:0]  inflight;
    logic [OBUF_CW-1:0]    obuf_cnt;
    logic                  push;
    logic                  issue;

    // Valid/ready: a word moves on a cycle where valid and ready are both high;
    // valid never waits on ready, and ready never depends on the same-side valid.
    assign full     = (ram_cnt == (ADDR_WIDTH + 1)'(DEPTH));
    assign in_ready = ~rst & ram_init_done & ~full;
    assign push     = in_valid & in_ready;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CNT_WIDTH'(rd_vld[i]);
    end

    // Reads are only issued when the buffer is guaranteed a slot on landing,
    // so out_ready never enters the issue path.
    assign issue = ~rst & ram_init_done & (ram_cnt != '0) &
                   ((inflight + CNT_WIDTH'(obuf_cnt)) < CNT_WIDTH'(OBUF_DEPTH));

    assign ram_wea   = push;
    assign ram_addra = wr_ptr;
    assign ram_dina  = in_data;
    assign ram_addrb = rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ram_cnt <= '0;
        end else begin
            if (push)  wr_ptr <= ADDR_WIDTH'(next_ptr(32'(wr_ptr), 32'(DEPTH)));
            if (issue) rd_ptr <= ADDR_WIDTH'(next_ptr(32'(rd_ptr), 32'(DEPTH)));
            case ({push, issue})
                2'b10:   ram_cnt <= ram_cnt + 1'b1;
                2'b01:   ram_cnt <= ram_cnt - 1'b1;
                default: ram_cnt <= ram_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld <= '0;
        end else begin
            rd_vld[0] <= issue;
            for (int i = 1; i < RD_LATENCY; i++) rd_vld[i] <= rd_vld[i-1];
        end
    end

    sdpram_fifo_obuf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (OBUF_DEPTH),
        .CNT_W      (OBUF_CW)
    ) u_obuf (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (rd_vld[RD_LATENCY-1]),
        .wr_data   (ram_doutb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .obuf_cnt  (obuf_cnt)
    );

    assign count = CNT_WIDTH'(ram_cnt) + inflight + CNT_WIDTH'(obuf_cnt);
    assign empty = (count == '0);

endmodule

// File: tb/tb_sdpram_stream_fifo_ctrl.sv
// Bench for sdpram_stream_fifo_ctrl: RAM model, queue-level occupancy model
// checked every cycle, scoreboard on popped words, and directed scenarios.
module tb_sdpram_stream_fifo_ctrl;

    localparam int W     = 72;
    localparam int DEPTH = 128;
    localparam int RDL   = 2;
    localparam int AW    = 7;
    localparam int CW    = 8;
    localparam int OBD   = RDL + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          ram_wea;
    logic [AW-1:0] ram_addra;
    logic [W-1:0]  ram_dina;
    logic [AW-1:0] ram_addrb;
    logic [W-1:0]  ram_doutb;
    logic          ram_init_done;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;

    sdpram_stream_fifo_ctrl #(
        .DATA_WIDTH (W),
        .DEPTH      (DEPTH),
        .RD_LATENCY (RDL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .ram_wea       (ram_wea),
        .ram_addra     (ram_addra),
        .ram_dina      (ram_dina),
        .ram_addrb     (ram_addrb),
        .ram_doutb     (ram_doutb),
        .ram_init_done (ram_init_done),
        .count         (count),
        .full          (full),
        .empty         (empty)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- RAM model (2-cycle read latency, read-first) ----------------
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] addr_d1;
    always @(posedge clk) begin
        if (ram_wea) mem[ram_addra] <= ram_dina;
        addr_d1   <= ram_addrb;
        ram_doutb <= mem[addr_d1];
    end

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int n_pops  = 0;
    int max_cnt = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
    endtask

    // ---------------- model + scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_ram[$];
    logic [W-1:0] m_fl_d[$];
    int           m_fl_a[$];
    logic [W-1:0] m_ob[$];
    int           wr_total = 0;
    int           rd_total = 0;
    int           e_cnt;
    bit           e_full, e_in_ready, e_out_valid, e_push, e_issue;

    always @(negedge clk) begin
        if (chk_en) begin
            e_full      = (m_ram.size() == DEPTH);
            e_cnt       = m_ram.size() + m_fl_d.size() + m_ob.size();
            e_in_ready  = !rst && ram_init_done && !e_full;
            e_out_valid = (m_ob.size() != 0);
            e_push      = e_in_ready && in_valid;

            chk("in_ready", in_ready, e_in_ready);
            chk("out_valid", out_valid, e_out_valid);
            if (e_out_valid) chk("out_data", out_data, m_ob[0]);
            chk("count", count, e_cnt);
            chk("full", full, e_full);
            chk("empty", empty, e_cnt == 0);
            chk("ram_wea", ram_wea, e_push);
            chk("ram_addra", ram_addra, wr_total % DEPTH);
            chk("ram_addrb", ram_addrb, rd_total % DEPTH);
            if (e_push) chk("ram_dina", ram_dina, in_data);
            if (int'(count) > max_cnt) max_cnt = int'(count);

            if (rst) begin
                m_ram.delete(); m_fl_d.delete(); m_fl_a.delete(); m_ob.delete();
                exp_q.delete();
                wr_total = 0;
                rd_total = 0;
            end else begin
                e_issue = ram_init_done && (m_ram.size() != 0) &&
                          (m_fl_d.size() + m_ob.size() < OBD);
                if (e_out_valid && out_ready) begin
                    if (exp_q.size() != 0) chk("sb_order", out_data, exp_q.pop_front());
                    else timeout("sb_underflow");
                    void'(m_ob.pop_front());
                    n_pops++;
                end
                if (m_fl_a.size() != 0 && m_fl_a[0] == RDL - 1) begin
                    m_ob.push_back(m_fl_d.pop_front());
                    void'(m_fl_a.pop_front());
                end
                foreach (m_fl_a[i]) m_fl_a[i]++;
                if (e_issue) begin
                    m_fl_d.push_back(m_ram.pop_front());
                    m_fl_a.push_back(0);
                    rd_total++;
                end
                if (e_push) begin
                    m_ram.push_back(in_data);
                    exp_q.push_back(in_data);
                    wr_total++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_word(input logic [W-1:0] d, output int push_cyc);
        bit done;
        done     = 1'b0;
        push_cyc = -1;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                done     = 1'b1;
                push_cyc = cyc;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) timeout("push_word");
    endtask

    task automatic wait_empty(input int bound, input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            @(negedge clk);
            if (empty) done = 1'b1;
            @(posedge clk); #1;
        end
        if (!done) timeout(name);
    endtask

    task automatic wait_out_valid(input int bound, input string name, output int seen_cyc);
        bit done;
        done     = 1'b0;
        seen_cyc = -1;
        for (int i = 0; i < bound && !done; i++) begin
            @(negedge clk);
            if (out_valid) begin
                done     = 1'b1;
                seen_cyc = cyc;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!done) timeout(name);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int tp, tv, base, accepted, drop_pops;
        bit stop;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; ram_init_done = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ram_wea", ram_wea, 0);
        chk("rst_ram_addra", ram_addra, 0);
        chk("rst_ram_addrb", ram_addrb, 0);
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_empty", empty, 1);
        @(posedge clk); #1;

        // Init gating
        in_valid = 1'b1; in_data = W'('h11);
        repeat (20) begin
            @(negedge clk);
            chk("gate_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        ram_init_done = 1'b1;
        push_word(W'('h11), tp);
        wait_out_valid(20, "gate_out_valid", tv);
        chk("gate_latency", tv - tp, 4);
        chk("gate_data", out_data, 'h11);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_empty(20, "gate_drain");

        // Streaming
        base = n_pops; max_cnt = 0;
        for (int i = 0; i < 300; i++) push_word(W'(i), tp);
        wait_empty(50, "stream_drain");
        chk("stream_pops", n_pops - base, 300);
        chk("stream_max_count", max_cnt, 4);

        // Fill to full
        out_ready = 1'b0; accepted = 0; stop = 1'b0;
        for (int i = 0; i < 200 && !stop; i++) begin
            in_valid = 1'b1; in_data = W'(1000 + accepted);
            @(negedge clk);
            if (!in_ready) stop = 1'b1;
            else accepted++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("fill_accepted", accepted, 132);
        @(negedge clk);
        chk("fill_full", full, 1);
        chk("fill_count", count, 132);
        @(posedge clk); #1;
        base = n_pops; out_ready = 1'b1;
        wait_empty(400, "fill_drain");
        chk("fill_pops", n_pops - base, 132);
        @(negedge clk);
        chk("fill_empty", empty, 1);
        @(posedge clk); #1;

        // Random backpressure
        base = n_pops;
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = W'({$urandom(), $urandom(), $urandom()});
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        wait_empty(400, "rand_drain");
        chk("rand_balance", exp_q.size(), 0);

        // Reset mid-operation
        out_ready = 1'b0;
        for (int i = 0; i < 40; i++) push_word(W'(2000 + i), tp);
        @(negedge clk);
        chk("pre_rst_count", count, 40);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_count", count, 0);
        chk("post_rst_out_valid", out_valid, 0);
        @(posedge clk); #1;
        push_word(W'('hAA), tp);
        wait_out_valid(20, "post_rst_out", tv);
        chk("post_rst_first", out_data, 'hAA);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_empty(20, "post_rst_drain");

        // Init drop with reads in flight
        base = n_pops; drop_pops = 0;
        push_word(W'('hA1), tp);
        push_word(W'('hA2), tp);
        push_word(W'('hA3), tp);
        ram_init_done = 1'b0;
        in_valid = 1'b1; in_data = W'('hA4);
        repeat (3) begin
            @(negedge clk);
            chk("drop_no_push", ram_wea, 0);
            if (out_valid && out_ready) drop_pops++;
            @(posedge clk); #1;
        end
        ram_init_done = 1'b1;
        push_word(W'('hA4), tp);
        push_word(W'('hA5), tp);
        wait_empty(30, "drop_drain");
        chk("drop_pops_during", drop_pops, 2);
        chk("drop_total_pops", n_pops - base, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
